// File: rtl/matmul_pkg.sv
// matmul_pkg: shared state encoding, limits and index-width helper for matrix_mult_seq.
package matmul_pkg;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam int MAT_N_MAX = 8;
    function automatic int idx_w(input int n);
        return $clog2(n * n);
    endfunction
endpackage

// File: rtl/matrix_mult_seq_mac_unit.sv
// mac_unit: combinational multiply-accumulate, acc_in + a*b truncated to DATA_W.
module mac_unit #(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] acc_in,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] acc_out
);
    assign acc_out = acc_in + a * b;
endmodule

// File: rtl/matrix_mult_seq.sv
// matrix_mult_seq: sequential N x N matrix multiply C = A x B with one shared MAC.
// Define MATMUL_ACCUM_EN to add the accum input (C = C + A x B when latched high on start).
module matrix_mult_seq import matmul_pkg::*; #(
    parameter int DATA_W = 32,
    parameter int N      = 3,
    parameter int IDX_W  = idx_w(N)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
`ifdef MATMUL_ACCUM_EN
    input  logic              accum,
`endif
    output logic              busy,
    output logic              done,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);
    localparam int CW = $clog2(MAT_N_MAX);
    localparam logic [CW-1:0] LAST = CW'(N - 1);
    localparam logic [IDX_W-1:0] NN_LAST = IDX_W'(N * N - 1);
    typedef logic [DATA_W-1:0] bank_t [N*N];

    state_t state_q, state_d;
    logic [CW-1:0] i_q, i_d, j_q, j_d, k_q, k_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    bank_t a_q, a_d, b_q, b_d, c_q, c_d;
    logic busy_q, done_q;
    logic [IDX_W-1:0] a_idx, b_idx, c_idx;
    logic [DATA_W-1:0] seed, mac_in, mac_out;
`ifdef MATMUL_ACCUM_EN
    logic accum_q, accum_d;
`endif

    assign a_idx = IDX_W'(int'(i_q) * N + int'(k_q));
    assign b_idx = IDX_W'(int'(k_q) * N + int'(j_q));
    assign c_idx = IDX_W'(int'(i_q) * N + int'(j_q));
`ifdef MATMUL_ACCUM_EN
    // C[i][j] is only rewritten at k==N-1, so at k==0 it still holds the previous result
    assign seed = accum_q ? c_q[c_idx] : '0;
`else
    assign seed = '0;
`endif
    assign mac_in = (k_q == '0) ? seed : acc_q;

    mac_unit #(.DATA_W(DATA_W)) u_mac (
        .acc_in (mac_in),
        .a      (a_q[a_idx]),
        .b      (b_q[b_idx]),
        .acc_out(mac_out)
    );

    always_comb begin
        state_d = state_q;
        i_d = i_q;
        j_d = j_q;
        k_d = k_q;
        acc_d = acc_q;
        a_d = a_q;
        b_d = b_q;
        c_d = c_q;
`ifdef MATMUL_ACCUM_EN
        accum_d = (state_q == IDLE && start) ? accum : accum_q;
`endif
        if (state_q == CALC) begin
            k_d = (k_q == LAST) ? '0 : k_q + 1'b1;
            acc_d = (k_q == LAST) ? '0 : mac_out;
            if (k_q == LAST) begin
                c_d[c_idx] = mac_out;
                j_d = (j_q == LAST) ? '0 : j_q + 1'b1;
                if (j_q == LAST) begin
                    i_d = (i_q == LAST) ? '0 : i_q + 1'b1;
                    state_d = (i_q == LAST) ? DONE : CALC;
                end
            end
        end else begin
            if (wr_en && wr_addr <= NN_LAST) begin
                if (wr_sel) b_d[wr_addr] = wr_data;
                else        a_d[wr_addr] = wr_data;
            end
            state_d = (state_q == IDLE && start) ? CALC : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            i_q <= '0;
            j_q <= '0;
            k_q <= '0;
            acc_q <= '0;
            a_q <= '{default: '0};
            b_q <= '{default: '0};
            c_q <= '{default: '0};
            busy_q <= 1'b0;
            done_q <= 1'b0;
`ifdef MATMUL_ACCUM_EN
            accum_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            i_q <= i_d;
            j_q <= j_d;
            k_q <= k_d;
            acc_q <= acc_d;
            a_q <= a_d;
            b_q <= b_d;
            c_q <= c_d;
            busy_q <= (state_d == CALC);
            done_q <= (state_d == DONE);
`ifdef MATMUL_ACCUM_EN
            accum_q <= accum_d;
`endif
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign rd_data = (rd_idx <= NN_LAST) ? c_q[rd_idx] : '0;
endmodule
